// File: rtl/mem_arbiter.sv
// Byte-serial owner of the shared RAM port; MEM has fixed priority over IF. Reads finish N+2 cycles after the
// request and writes N+1 cycles after it. Requesters hold req while busy, and a granted access always completes.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_busy_o,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_busy_o,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       acc;
    logic              we_r;

    logic [2:0]        cnt_nxt;
    logic [1:0]        cnt_m1;
    logic [31:0]       rd_word;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign cnt_nxt = cnt + 3'd1;
    assign cnt_m1  = cnt[1:0] - 2'd1;
    // Read data arrives one cycle behind its address, so the byte on ram_din_i belongs to index cnt-1.
    assign rd_word = acc | ({24'd0, ram_din_i} << {cnt_m1, 3'b000});

    assign if_busy_o  = (state != IDLE);
    assign mem_busy_o = (state != IDLE);
    // Gated by rst so a store caught by reset stops writing in the reset cycle itself.
    assign ram_we_o   = we_r & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            nbytes      <= 3'd0;
            base        <= '0;
            wdata       <= 32'd0;
            acc         <= 32'd0;
            we_r        <= 1'b0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
            if_data_o   <= 32'd0;
            mem_rdata_o <= 32'd0;
            ram_addr_o  <= '0;
            ram_dout_o  <= 8'd0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    acc <= 32'd0;
                    // A requester's own done cycle masks its req so it cannot be granted twice.
                    if (mem_req_i && !mem_done_o) begin
                        base       <= mem_addr_i;
                        ram_addr_o <= mem_addr_i;
                        wdata      <= mem_wdata_i;
                        nbytes     <= size_bytes(mem_size_i);
                        if (mem_we_i) begin
                            state      <= MEM_WR;
                            we_r       <= 1'b1;
                            ram_dout_o <= mem_wdata_i[7:0];
                        end else begin
                            state <= MEM_RD;
                        end
                    end else if (if_req_i && !if_done_o) begin
                        base       <= if_addr_i;
                        ram_addr_o <= if_addr_i;
                        nbytes     <= 3'd4;
                        state      <= IF_RD;
                    end
                end
                MEM_WR: begin
                    if (cnt_nxt < nbytes) begin
                        cnt        <= cnt_nxt;
                        ram_addr_o <= base + {{(ADDR_W-3){1'b0}}, cnt_nxt};
                        ram_dout_o <= wdata[{cnt_nxt[1:0], 3'b000} +: 8];
                    end else begin
                        state      <= IDLE;
                        we_r       <= 1'b0;
                        mem_done_o <= 1'b1;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (cnt == nbytes) begin
                        state <= IDLE;
                        if (state == IF_RD) begin
                            if_data_o <= rd_word;
                            if_done_o <= 1'b1;
                        end else begin
                            mem_rdata_o <= rd_word;
                            mem_done_o  <= 1'b1;
                        end
                    end else begin
                        if (cnt != 3'd0)
                            acc <= rd_word;
                        cnt <= cnt_nxt;
                        if (cnt_nxt < nbytes)
                            ram_addr_o <= base + {{(ADDR_W-3){1'b0}}, cnt_nxt};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
